// File: rtl/lfsr_range_sampler.sv
// rtl/lfsr_range_sampler.sv - bounded random draw from an LFSR sample via restoring remainder
//
// Captures one LFSR sample on request and reduces it modulo `bound` with a
// bit-serial restoring remainder (one quotient bit per clock, WIDTH steps).
// A bound of zero skips the reduction and returns the raw sample.
//
// Ports:
//   clk      in   1      rising-edge clock (shared with the LFSR)
//   resetn   in   1      asynchronous active-low reset
//   rand_in  in   WIDTH  current LFSR output, captured on the accept edge only
//   req      in   1      draw request, level-sensitive, taken only while ready=1
//   bound    in   WIDTH  exclusive upper bound, captured with rand_in
//   ready    out  1      idle, able to accept a request
//   valid    out  1      one-cycle pulse, result is new this cycle
//   result   out  WIDTH  last completed draw, held until the next completion

module lfsr_range_sampler #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] rand_in,
    input  logic             req,
    input  logic [WIDTH-1:0] bound,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH:0]   rem;
    logic [WIDTH:0]   rem_s;
    logic [WIDTH:0]   rem_nxt;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             last_step;

    // The shifted remainder needs WIDTH+1 bits: with a divisor above
    // 2^(WIDTH-1) the stored remainder can have its top data bit set, and
    // shifting it left must not drop that bit before the compare.
    // rem itself always holds a value below divisor, so shifting the whole
    // register and keeping WIDTH+1 bits equals {rem[WIDTH-1:0], msb}.
    always_comb begin
        rem_s   = (rem << 1) | {{WIDTH{1'b0}}, dividend[WIDTH-1]};
        rem_nxt = rem_s;
        if (rem_s >= {1'b0, divisor}) begin
            rem_nxt = rem_s - {1'b0, divisor};
        end
    end

    assign last_step = (cnt == CW'(WIDTH - 1));
    assign accept    = (state == S_IDLE) && req;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and outputs; ready depends on state only, so the accept
    // decision never loops back through valid.
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        valid     = 1'b0;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (req) begin
                    state_nxt = (bound == '0) ? S_DONE : S_DIV;
                end
            end
            S_DIV: begin
                if (last_step) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                valid     = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dividend <= '0;
            divisor  <= '0;
            rem      <= '0;
            cnt      <= '0;
            result   <= '0;
        end else if (accept) begin
            dividend <= rand_in;
            divisor  <= bound;
            rem      <= '0;
            cnt      <= '0;
            if (bound == '0) begin
                result <= rand_in;
            end
        end else if (state == S_DIV) begin
            dividend <= dividend << 1;
            rem      <= rem_nxt;
            cnt      <= cnt + CW'(1);
            if (last_step) begin
                result <= rem_nxt[WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_lfsr_range_sampler.sv
// tb/tb_lfsr_range_sampler.sv - self-checking bench for lfsr_range_sampler

module tb_lfsr_range_sampler;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req = 1'b0;
    logic [31:0] rand_in = '0;
    logic [31:0] bound = '0;
    logic        ready;
    logic        valid;
    logic [31:0] result;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];

    lfsr_range_sampler #(.WIDTH(32)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .rand_in (rand_in),
        .req     (req),
        .bound   (bound),
        .ready   (ready),
        .valid   (valid),
        .result  (result)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model(input logic [31:0] r, input logic [31:0] b);
        return (b == 32'd0) ? r : (r % b);
    endfunction

    // Wait for ready, present a request, push the expected result, and
    // return 1 time unit after the accept edge.
    task automatic issue(input logic [31:0] r, input logic [31:0] b, input bit push, input bit hold);
        int w;
        w = 0;
        @(negedge clk);
        while (ready !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        n_checks++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_ready: ready=%b required 1", ready);
        end
        rand_in = r;
        bound   = b;
        req     = 1'b1;
        if (push) exp_q.push_back(model(r, b));
        @(posedge clk);
        #1;
        if (!hold) req = 1'b0;
    endtask

    // Observe from the cycle after the accept edge until ready returns.
    // lat = post-accept edges before valid is seen, rl = cycles with ready low.
    task automatic collect(input int chg_at, input logic [31:0] nb, input logic [31:0] nr,
                           output int lat, output int rl, output int nvalid,
                           output logic [31:0] res, output logic [31:0] res_hold);
        lat = -1; rl = 0; nvalid = 0; res = '0; res_hold = '0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (k == chg_at) begin
                bound   = nb;
                rand_in = nr;
            end
            if (ready !== 1'b1) rl++;
            if (valid === 1'b1) begin
                nvalid++;
                if (lat < 0) begin
                    lat = k;
                    res = result;
                end
            end
            if (ready === 1'b1) begin
                res_hold = result;
                break;
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1 req = ~req;
            @(negedge clk);
            n_checks++;
            if (ready !== 1'b1 || valid !== 1'b0 || result !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_hold: ready=%b valid=%b result=%h required 1 0 0", ready, valid, result);
            end
        end
        req    = 1'b0;
        resetn = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ready !== 1'b1 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: ready=%b valid=%b required 1 0", ready, valid);
        end
    endtask

    task automatic test_basic();
        int lat, rl, nv;
        logic [31:0] res, hold, exp;
        issue(32'hDEADBEEF, 32'd10, 1'b1, 1'b0);
        collect(-1, '0, '0, lat, rl, nv, res, hold);
        exp = exp_q.size() > 0 ? exp_q.pop_front() : 32'hxxxxxxxx;
        n_checks++;
        if (res !== exp || res !== 32'd9) begin
            n_fail++;
            $display("FAIL basic_result: got %h required %h", res, exp);
        end
        n_checks++;
        if (lat != 32 || nv != 1) begin
            n_fail++;
            $display("FAIL basic_latency: lat=%0d pulses=%0d required 32 1", lat, nv);
        end
        n_checks++;
        if (rl != 33) begin
            n_fail++;
            $display("FAIL basic_ready_low: got %0d cycles required 33", rl);
        end
        n_checks++;
        if (hold !== 32'd9) begin
            n_fail++;
            $display("FAIL basic_result_held: got %h required 9", hold);
        end
    endtask

    task automatic test_bypass();
        int lat, rl, nv;
        logic [31:0] res, hold, exp;
        issue(32'h12345678, 32'd0, 1'b1, 1'b0);
        collect(-1, '0, '0, lat, rl, nv, res, hold);
        exp = exp_q.size() > 0 ? exp_q.pop_front() : 32'hxxxxxxxx;
        n_checks++;
        if (res !== exp || res !== 32'h12345678) begin
            n_fail++;
            $display("FAIL bypass_result: got %h required %h", res, exp);
        end
        n_checks++;
        if (lat != 0 || rl != 1 || nv != 1) begin
            n_fail++;
            $display("FAIL bypass_timing: lat=%0d ready_low=%0d pulses=%0d required 0 1 1", lat, rl, nv);
        end
    endtask

    task automatic test_wide();
        logic [31:0] bnd [2];
        logic [31:0] want [2];
        int lat, rl, nv;
        logic [31:0] res, hold, exp;
        bnd[0] = 32'hFFFFFFFF; want[0] = 32'h00000000;
        bnd[1] = 32'h80000001; want[1] = 32'h7FFFFFFE;
        for (int i = 0; i < 2; i++) begin
            issue(32'hFFFFFFFF, bnd[i], 1'b1, 1'b0);
            collect(-1, '0, '0, lat, rl, nv, res, hold);
            exp = exp_q.size() > 0 ? exp_q.pop_front() : 32'hxxxxxxxx;
            n_checks++;
            if (res !== exp || res !== want[i] || lat != 32) begin
                n_fail++;
                $display("FAIL wide_%0d: got %h lat=%0d required %h lat=32", i, res, lat, want[i]);
            end
        end
    endtask

    task automatic test_handshake();
        int lat, rl, nv;
        logic [31:0] res, hold, exp;
        issue(32'h0BADF00D, 32'd1, 1'b1, 1'b1);
        collect(10, 32'd7, 32'd1000, lat, rl, nv, res, hold);
        exp = exp_q.size() > 0 ? exp_q.pop_front() : 32'hxxxxxxxx;
        n_checks++;
        if (res !== exp || res !== 32'd0 || lat != 32) begin
            n_fail++;
            $display("FAIL handshake_first: got %h lat=%0d required 0 lat=32", res, lat);
        end
        exp_q.push_back(model(rand_in, bound));
        @(posedge clk);
        #1;
        n_checks++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL handshake_reaccept: ready=%b required 0", ready);
        end
        req = 1'b0;
        collect(-1, '0, '0, lat, rl, nv, res, hold);
        exp = exp_q.size() > 0 ? exp_q.pop_front() : 32'hxxxxxxxx;
        n_checks++;
        if (res !== exp || !(res < 32'd7) || lat != 32) begin
            n_fail++;
            $display("FAIL handshake_second: got %h lat=%0d required %h lat=32", res, lat, exp);
        end
    endtask

    task automatic test_reset_mid();
        int lat, rl, nv;
        int seen;
        logic [31:0] res, hold, exp;
        issue(32'hABCDEF01, 32'd13, 1'b0, 1'b0);
        repeat (15) @(posedge clk);
        #1 resetn = 1'b0;
        #1;
        n_checks++;
        if (ready !== 1'b1 || valid !== 1'b0 || result !== 32'd0) begin
            n_fail++;
            $display("FAIL midreset_async: ready=%b valid=%b result=%h required 1 0 0", ready, valid, result);
        end
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (valid !== 1'b0) seen++;
            if (i == 4) resetn = 1'b1;
        end
        n_checks++;
        if (seen != 0 || ready !== 1'b1 || result !== 32'd0) begin
            n_fail++;
            $display("FAIL midreset_abort: valid_cycles=%0d ready=%b result=%h required 0 1 0", seen, ready, result);
        end
        issue(32'd100, 32'd7, 1'b1, 1'b0);
        collect(-1, '0, '0, lat, rl, nv, res, hold);
        exp = exp_q.size() > 0 ? exp_q.pop_front() : 32'hxxxxxxxx;
        n_checks++;
        if (res !== exp || res !== 32'd2 || lat != 32) begin
            n_fail++;
            $display("FAIL midreset_redraw: got %h lat=%0d required 2 lat=32", res, lat);
        end
    endtask

    task automatic test_back_to_back();
        int lat, rl, nv;
        logic [31:0] res, hold, exp, r, b;
        for (int i = 0; i < 8; i++) begin
            r = $urandom;
            case (i % 4)
                0: b = $urandom_range(2, 1000);
                1: b = 32'd1;
                2: b = 32'h80000000 | $urandom;
                default: b = $urandom;
            endcase
            issue(r, b, 1'b1, 1'b0);
            collect(-1, '0, '0, lat, rl, nv, res, hold);
            exp = exp_q.size() > 0 ? exp_q.pop_front() : 32'hxxxxxxxx;
            n_checks++;
            if (res !== exp || lat != ((b == 0) ? 0 : 32) || nv != 1) begin
                n_fail++;
                $display("FAIL b2b_%0d: r=%h b=%h got %h lat=%0d required %h", i, r, b, res, lat, exp);
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bypass();
        test_wide();
        test_handshake();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
